// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 in-place DIT FFT address sequencer.
package fft_pkg;

  localparam int LOG2N_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } fft_state_e;

  // Reverses the low 'width' bits of value; bits at and above width come back as 0.
  function automatic logic [15:0] bitrev(input logic [15:0] value, input int width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width) r[4'(i)] = value[4'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly descriptor generator: (stage, butterfly index) -> operand addresses and twiddle index.
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic [3:0]       stg_i,
  input  logic [LOG2N-2:0] k_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] tw_idx_o
);

  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [4:0]       grp_sh;
  logic [4:0]       tw_sh;

  always_comb begin
    k_ext    = {1'b0, k_i};
    half     = LOG2N'(1) << stg_i;
    pos      = k_ext & (half - LOG2N'(1));
    grp      = k_ext >> stg_i;
    grp_sh   = {1'b0, stg_i} + 5'd1;
    tw_sh    = 5'(LOG2N - 1) - {1'b0, stg_i};
    // Each group spans 2*half addresses; pos selects the pair inside it.
    addr_a_o = (grp << grp_sh) | pos;
    addr_b_o = addr_a_o + half;
    tw_idx_o = (LOG2N-1)'(pos) << tw_sh;
  end

endmodule

// File: rtl/fft_addr_ctrl.sv
// Frame sequencer for a radix-2 in-place DIT FFT: bit-reversed sample load, then stage-by-stage butterflies.
//   state      | meaning
//   ST_IDLE    | waiting for a rising edge of run
//   ST_LOAD    | writing N samples to bit-reversed RAM addresses
//   ST_COMPUTE | issuing (N/2)*LOG2N butterfly descriptors
//   ST_DONE    | one-cycle frame-complete pulse
module fft_addr_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [3:0]       stage,
  output logic             busy,
  output logic             done
);

  localparam logic [LOG2N-1:0] CNT_LAST = '1;
  localparam logic [LOG2N-2:0] K_LAST   = '1;
  localparam logic [3:0]       STG_LAST = 4'(LOG2N - 1);

  fft_state_e       state_q;
  logic             run_q;
  logic [LOG2N-1:0] cnt_q;
  logic [LOG2N-2:0] k_q;
  logic [3:0]       stg_q;

  logic             start_evt;
  logic             in_load;
  logic             in_compute;
  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [LOG2N-2:0] gen_tw;

  fft_bf_addr_gen #(.LOG2N(LOG2N)) u_bf_addr_gen (
    .stg_i    (stg_q),
    .k_i      (k_q),
    .addr_a_o (gen_a),
    .addr_b_o (gen_b),
    .tw_idx_o (gen_tw)
  );

  assign start_evt  = run & ~run_q;
  assign in_load    = (state_q == ST_LOAD);
  assign in_compute = (state_q == ST_COMPUTE);

  // run gates both handshakes so an abort can never coincide with a transfer.
  assign in_ready  = run & in_load;
  assign wr_en     = in_valid & in_ready;
  assign bf_valid  = run & in_compute;
  assign wr_addr   = in_load ? LOG2N'(bitrev(16'(cnt_q), LOG2N)) : '0;
  assign bf_addr_a = in_compute ? gen_a  : '0;
  assign bf_addr_b = in_compute ? gen_b  : '0;
  assign tw_idx    = in_compute ? gen_tw : '0;
  assign stage     = in_compute ? stg_q  : '0;
  assign busy      = in_load | in_compute;
  assign done      = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      k_q     <= '0;
      stg_q   <= '0;
    end else begin
      run_q <= run;
      case (state_q)
        ST_IDLE: begin
          if (start_evt) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!run) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (wr_en) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_COMPUTE;
              cnt_q   <= '0;
              k_q     <= '0;
              stg_q   <= '0;
            end else begin
              cnt_q <= cnt_q + LOG2N'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (!run) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            stg_q   <= '0;
          end else if (bf_ready) begin
            if (k_q == K_LAST) begin
              k_q <= '0;
              if (stg_q == STG_LAST) begin
                state_q <= ST_DONE;
                stg_q   <= '0;
              end else begin
                stg_q <= stg_q + 4'd1;
              end
            end else begin
              k_q <= k_q + (LOG2N-1)'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Scoreboard bench for fft_addr_ctrl at LOG2N=3: load order, butterfly order, stalls, abort, restart and reset.
module tb_fft_addr_ctrl;

  localparam int LOG2N = 3;
  localparam int N     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             in_valid;
  logic             in_ready;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr;
  logic             bf_valid;
  logic             bf_ready;
  logic [LOG2N-1:0] bf_addr_a;
  logic [LOG2N-1:0] bf_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic [3:0]       stage;
  logic             busy;
  logic             done;

  fft_addr_ctrl #(.LOG2N(LOG2N)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .bf_addr_a (bf_addr_a),
    .bf_addr_b (bf_addr_b),
    .tw_idx    (tw_idx),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int wr_q[$];
  int bf_q[$];
  int cyc_n, wr_seen, bf_seen, done_seen, done_cyc, last_bf_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Bit-reversed load order and butterfly order for N=8, built independently of the DUT.
  task automatic push_frame();
    int rev_tab[8];
    int half, a, b, tw;
    rev_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
    wr_q.delete();
    bf_q.delete();
    for (int i = 0; i < N; i++) wr_q.push_back(rev_tab[i]);
    for (int s = 0; s < LOG2N; s++) begin
      half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++) begin
        for (int p = 0; p < half; p++) begin
          a  = g * 2 * half + p;
          b  = a + half;
          tw = p * (N / (2 * half));
          bf_q.push_back((s << 24) | (a << 16) | (b << 8) | tw);
        end
      end
    end
  endtask

  task automatic monitor();
    logic [31:0] desc;
    if (wr_en) begin
      chk("wr_expected", 32'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) chk("wr_addr", 32'(wr_addr), wr_q.pop_front());
      wr_seen++;
    end
    if (bf_valid) begin
      desc = (32'(stage) << 24) | (32'(bf_addr_a) << 16) | (32'(bf_addr_b) << 8) | 32'(tw_idx);
      chk("bf_expected", 32'(bf_q.size() > 0), 1);
      if (bf_q.size() > 0) begin
        if (bf_ready) begin
          chk("bf_desc", desc, bf_q.pop_front());
          bf_seen++;
          last_bf_cyc = cyc_n;
        end else begin
          chk("bf_hold", desc, bf_q[0]);
        end
      end
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc_n;
    end
  endtask

  // Inputs change right after the falling edge; outputs are sampled 1ns later, before the next rising edge.
  task automatic cyc(input logic r, input logic iv, input logic br);
    @(negedge clk);
    run      = r;
    in_valid = iv;
    bf_ready = br;
    #1;
    cyc_n++;
    monitor();
  endtask

  task automatic frame(input bit stall, input int abort_after);
    bit   pat[4];
    int   pat_i, start_c;
    bit   ir_pending, ir_done, aborted;
    logic br;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc(1'b0, 1'b0, 1'b0);
    push_frame();
    wr_seen = 0; bf_seen = 0; done_seen = 0; done_cyc = 0; last_bf_cyc = 0;
    pat_i = 0; ir_pending = 0; ir_done = 0; aborted = 0;
    start_c = cyc_n + 1;
    for (int i = 0; i < 200; i++) begin
      if (abort_after >= 0 && bf_seen == abort_after) begin
        cyc(1'b0, 1'b1, 1'b1);
        chk("abort_bf_valid", 32'(bf_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("abort_idle_busy", 32'(busy), 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("abort_no_done", 32'(done_seen), 0);
        aborted = 1;
        break;
      end
      br = stall ? pat[pat_i % 4] : 1'b1;
      cyc(1'b1, 1'b1, br);
      if (bf_valid) pat_i++;
      if (ir_pending) begin
        chk("in_ready_after_load", 32'(in_ready), 0);
        ir_pending = 0;
      end
      if (wr_seen == N && !ir_done) begin
        ir_pending = 1;
        ir_done    = 1;
      end
      if (done_seen != 0) break;
    end
    if (abort_after >= 0) begin
      chk("abort_reached", 32'(aborted), 1);
    end else begin
      chk("done_seen", 32'(done_seen), 1);
      chk("wr_count", 32'(wr_seen), N);
      chk("bf_count", 32'(bf_seen), (N / 2) * LOG2N);
      chk("done_after_last_bf", 32'(done_cyc - last_bf_cyc), 1);
      if (!stall) chk("frame_latency", 32'(done_cyc - start_c), 1 + N + (N / 2) * LOG2N);
      cyc(1'b1, 1'b1, 1'b1);
      chk("done_pulse_width", 32'(done), 0);
      chk("idle_after_done", 32'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; in_valid = 1'b0; bf_ready = 1'b0;
    cyc_n = 0; wr_seen = 0; bf_seen = 0; done_seen = 0; done_cyc = 0; last_bf_cyc = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_bf_valid", 32'(bf_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addrs", {8'(wr_addr), 8'(bf_addr_a), 8'(bf_addr_b), 4'(tw_idx), stage}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Uninterrupted frame, then run held high must not restart.
    frame(1'b0, -1);
    repeat (4) cyc(1'b1, 1'b1, 1'b1);
    chk("held_run_busy", 32'(busy), 0);
    chk("held_run_in_ready", 32'(in_ready), 0);

    frame(1'b1, -1);
    frame(1'b0, 5);
    frame(1'b0, -1);

    // Asynchronous reset in the middle of the butterfly phase.
    cyc(1'b0, 1'b0, 1'b0);
    push_frame();
    bf_seen = 0;
    for (int i = 0; i < 60 && bf_seen < 3; i++) cyc(1'b1, 1'b1, 1'b1);
    chk("pre_reset_in_compute", 32'(bf_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bf_valid", 32'(bf_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_addrs", {8'(wr_addr), 8'(bf_addr_a), 8'(bf_addr_b), 4'(tw_idx), stage}, 0);
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr_q.delete();
    bf_q.delete();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      chk("post_rst_quiet", {31'(busy), wr_en}, 0);
    end
    frame(1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
